// File: rtl/program_loader_if.sv
// Loader bus: instruction-word stream in, IM write port and CPU boot control out.
// The chk_error signal exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
interface program_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  im_en_write;
    logic [ADDR_WIDTH-1:0] im_address;
    logic [DATA_WIDTH-1:0] im_data;
    logic                  cpu_reset;
    logic                  cpu_start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  overflow;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic                  chk_error;
`endif

    // Word source / observer side.
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, im_en_write, im_address, im_data,
        input  cpu_reset, cpu_start, busy, done, word_count, overflow
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , input chk_error
`endif
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, im_en_write, im_address, im_data,
        output cpu_reset, cpu_start, busy, done, word_count, overflow
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , output chk_error
`endif
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: buffers a valid/ready word stream in a small FIFO,
// writes the words to instruction memory from address 0, then releases the CPU
// with a reset pulse followed by start.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN: the in_last word becomes an XOR
// checksum of the written words; a mismatch parks the loader in ERROR.
module program_loader #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 10,
    parameter int FIFO_DEPTH        = 4,
    parameter int BOOT_RESET_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    program_loader_if.slave  bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BOOT_W = (BOOT_RESET_CYCLES > 1) ? $clog2(BOOT_RESET_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] IM_CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, BOOT, RUN, ERROR} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      head_reg, tail_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [BOOT_W-1:0]     boot_cnt_reg;
    logic                  im_en_write_reg;
    logic [ADDR_WIDTH-1:0] im_address_reg;
    logic [DATA_WIDTH-1:0] im_data_reg;
    logic [ADDR_WIDTH:0]   word_count_reg;
    logic                  overflow_reg;
    logic                  cpu_reset_reg, cpu_start_reg;

    logic fifo_full, fifo_empty, transfer, push, pop, im_full, write_word;

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign bus.in_ready = ((state_reg == IDLE) || (state_reg == LOAD)) && !fifo_full;
    assign transfer   = bus.in_valid && bus.in_ready;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // The checksum word is held aside, never buffered or written.
    assign push = transfer && !bus.in_last;
`else
    assign push = transfer;
`endif
    assign pop        = ((state_reg == LOAD) || (state_reg == DRAIN)) && !fifo_empty;
    assign im_full    = (word_count_reg == IM_CAPACITY);
    assign write_word = pop && !im_full;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_acc_reg, chk_word_reg;

    // Running XOR of words actually written, plus the captured checksum word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_acc_reg  <= '0;
            chk_word_reg <= '0;
        end else begin
            if (write_word)
                chk_acc_reg <= chk_acc_reg ^ fifo_mem[head_reg];
            if (transfer && bus.in_last)
                chk_word_reg <= bus.in_data;
        end
    end

    assign bus.chk_error = (state_reg == ERROR);
`endif

    // FIFO storage: write-only array, read through the registered IM outputs.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[tail_reg] <= bus.in_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push)
                tail_reg <= tail_reg + PTR_W'(1);
            if (pop)
                head_reg <= head_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    // IM write port: one registered write per pop, discarding once IM is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_en_write_reg <= 1'b0;
            im_address_reg  <= '0;
            im_data_reg     <= '0;
            word_count_reg  <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            im_en_write_reg <= write_word;
            if (write_word) begin
                im_address_reg <= word_count_reg[ADDR_WIDTH-1:0];
                im_data_reg    <= fifo_mem[head_reg];
                word_count_reg <= word_count_reg + (ADDR_WIDTH+1)'(1);
            end
            if (pop && im_full)
                overflow_reg <= 1'b1;
        end
    end

    // State register, BOOT cycle counter and registered CPU controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            boot_cnt_reg  <= '0;
            cpu_reset_reg <= 1'b1;
            cpu_start_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            boot_cnt_reg  <= (state_reg == BOOT) ? boot_cnt_reg + BOOT_W'(1) : '0;
            cpu_reset_reg <= (state_next != RUN);
            cpu_start_reg <= (state_next == RUN);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (transfer) state_next = bus.in_last ? DRAIN : LOAD;
            LOAD:  if (transfer && bus.in_last) state_next = DRAIN;
            DRAIN: begin
                if (fifo_empty) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_next = (chk_acc_reg == chk_word_reg) ? BOOT : ERROR;
`else
                    state_next = BOOT;
`endif
                end
            end
            BOOT:  if (boot_cnt_reg == BOOT_W'(BOOT_RESET_CYCLES - 1)) state_next = RUN;
            RUN:   state_next = RUN;
            ERROR: state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    assign bus.im_en_write = im_en_write_reg;
    assign bus.im_address  = im_address_reg;
    assign bus.im_data     = im_data_reg;
    assign bus.word_count  = word_count_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.cpu_reset   = cpu_reset_reg;
    assign bus.cpu_start   = cpu_start_reg;
    assign bus.busy        = (state_reg == LOAD) || (state_reg == DRAIN) || (state_reg == BOOT);
    assign bus.done        = (state_reg == RUN);
endmodule
